ysyx_220066_dmem_resp: RTL
==========================

Name: ysyx_220066_dmem_resp

Overview:
Memory-side responder for the core's data-memory load/store interface. Serves MemRd/MemWr requests from the core's data port, using the addr/wr_mask/data_Wr signals. Holds a doubleword-organised backing array, commits masked stores, and returns load data after a programmable latency with a valid/error pulse. It is the simulation-grade data memory model that plugs in where the separate read and write helpers sit today.

Parameters:
DEPTH, 4096, number of 64-bit doublewords in the backing array.
BASE, 64'h8000_0000, byte address of doubleword 0.
READ_LAT, 2, cycles from read acceptance to response (legal range 1..15).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
MemRd  input  1  load request, level; held by core until response seen
MemWr  input  1  store request, single-cycle
addr  input  64  byte address; bits [2:0] ignored for array indexing
wr_mask  input  8  byte-lane enables for store, bit i -> data_Wr[8i+7:8i]
data_Wr  input  64  store data
block  input  1  core stall; gates acceptance, holds pending response
data_Rd  output  64  load data, valid only while valid=1
valid  output  1  load response strobe
error  output  1  response carries an error, qualified by valid
busy  output  1  a load is in flight or a response is pending

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, data_Rd=0, valid=0, error=0, busy=0. Any in-flight load is aborted with no response. The array is not cleared.
- In range: BASE <= addr < BASE+DEPTH*8. Index = (addr-BASE)>>3.
- States: IDLE, WAIT, RESP.
- IDLE, store case: MemWr=1, MemRd=0, block=0.
  - In range: array[index] lanes with wr_mask=1 take data_Wr at this edge. No response, stay IDLE.
  - Out of range or wr_mask=0: dropped silently.
- IDLE, load case: MemRd=1, MemWr=0, block=0. Accept.
  - Latch index and an error flag (out of range).
  - counter <= READ_LAT-1.
  - Go to WAIT if READ_LAT>1, else RESP.
  - busy=1 from the next cycle.
- IDLE, MemRd=1 and MemWr=1 together with block=0: accept as a load with error forced. The store is not committed.
- WAIT: counter decrements each cycle; block does not stall the countdown. At counter==1 -> RESP. Array is read at the RESP entry edge, so a store cannot occur meanwhile; core holds the bus.
- RESP output: valid=1; data_Rd = array[index], or 0 if error; error as latched.
- RESP exit:
  - block=0: RESP lasts exactly one cycle, then IDLE.
  - block=1: hold RESP with valid, data and error stable until the first cycle block=0, then IDLE.
- Total load latency = READ_LAT cycles from the accept edge to the valid=1 cycle.
- Core drops MemRd in the cycle it samples valid. MemRd still high in IDLE after RESP is a new request (back-to-back loads, one-cycle IDLE gap).
- Requests while busy=1 are ignored, not queued; MemWr pulses during busy are lost. The core never issues them.
- Read-after-write to the same doubleword in consecutive cycles returns the new data.
- valid and error are registered outputs; data_Rd is registered, not combinational from the array.

Decomposition:
- Shared package/header:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - 64-bit XLEN constant
  - default BASE
- Natural sub-module: ysyx_220066_dmem_array.
  - Synchronous byte-masked write.
  - Registered read port addressed by index.
  - Keeps the protocol FSM separate from storage.

Test Plan:
1. Reset mid-WAIT: assert rst 1 cycle after load accept -> valid never pulses; busy=0, data_Rd=0 immediately after rst rises (async).
2. Store then load: MemWr addr=0x8000_0010, wr_mask=8'hFF, data=0x1122334455667788; then MemRd same addr, READ_LAT=2 -> valid=1 exactly 2 cycles after accept, data_Rd=0x1122334455667788, error=0.
3. Partial mask: store 0xAABBCCDD_EEFF0011 with wr_mask=8'h0F over the previous value -> load returns 0x11223344_EEFF0011.
4. Out of range: MemRd addr=0x7FFF_FFF8 -> valid with error=1, data_Rd=0. MemWr at BASE+DEPTH*8 -> no array change, confirmed by a boundary read.
5. Block hold: raise block during WAIT, keep it 3 cycles past RESP -> valid stays 1 with stable data until block falls, then 0; no new request accepted while block=1.
6. Back-to-back: MemRd held high across two responses at different addresses -> two valid pulses separated by READ_LAT+1 cycles. Also MemRd&MemWr together -> error response, store not committed.

Source files
------------

// File: rtl/ysyx_220066_dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: machine width,
// default memory base and the protocol state encoding.
package ysyx_220066_dmem_resp_pkg;

    localparam int XLEN = 64;

    localparam logic [XLEN-1:0] DEFAULT_BASE = 64'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/ysyx_220066_dmem_array.sv
// Doubleword-organised backing store for the data-memory responder.
// Byte-masked synchronous write port and a registered read port. The
// storage itself is never reset; only the read register clears on reset.
module ysyx_220066_dmem_array
    import ysyx_220066_dmem_resp_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_idx,
    input  logic [7:0]      wr_mask,
    input  logic [XLEN-1:0] wr_data,
    input  logic            rd_en,
    input  logic            rd_zero,
    input  logic [IW-1:0]   rd_idx,
    output logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] mem [DEPTH];

    // Commit the enabled byte lanes of a store.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Capture load data once per load; an erroring load returns zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_idx];
        end
    end

endmodule

// File: rtl/ysyx_220066_dmem_resp.sv
// Memory-side responder for the core's data port. Stores commit in the
// cycle they are presented; loads answer with a registered valid/error
// strobe READ_LAT cycles after acceptance and hold while the core stalls.
module ysyx_220066_dmem_resp
    import ysyx_220066_dmem_resp_pkg::*;
#(
    parameter int              DEPTH    = 4096,
    parameter logic [XLEN-1:0] BASE     = DEFAULT_BASE,
    parameter int              READ_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemRd,
    input  logic            MemWr,
    input  logic [XLEN-1:0] addr,
    input  logic [7:0]      wr_mask,
    input  logic [XLEN-1:0] data_Wr,
    input  logic            block,
    output logic [XLEN-1:0] data_Rd,
    output logic            valid,
    output logic            error,
    output logic            busy
);

    localparam int              IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [XLEN-1:0] SPAN     = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]      LAT_INIT = 4'(READ_LAT - 1);

    dmem_state_t     state;
    dmem_state_t     state_next;
    logic [3:0]      cnt;
    logic [3:0]      cnt_next;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_next;
    logic            err_q;
    logic            err_next;

    logic [XLEN-1:0] offset;
    logic            in_range;
    logic [IW-1:0]   cur_idx;

    logic            wr_en;
    logic            rd_en;
    logic [IW-1:0]   rd_idx;

    // Address decode: the subtraction wraps below BASE, so the lower bound
    // is checked explicitly.
    assign offset   = addr - BASE;
    assign in_range = (addr >= BASE) && (offset < SPAN);
    assign cur_idx  = IW'(offset >> 3);

    // Next-state, countdown and array-port control.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx_q;
        err_next   = err_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_idx     = idx_q;

        case (state)
            IDLE: begin
                if (!block) begin
                    if (MemRd) begin
                        // A simultaneous store turns the load into an error
                        // and is itself discarded.
                        idx_next = cur_idx;
                        err_next = !in_range || MemWr;
                        cnt_next = LAT_INIT;
                        if (READ_LAT > 1) begin
                            state_next = WAIT;
                        end else begin
                            state_next = RESP;
                            rd_en      = 1'b1;
                            rd_idx     = cur_idx;
                        end
                    end else if (MemWr && in_range) begin
                        wr_en = 1'b1;
                    end
                end
            end
            WAIT: begin
                // The countdown ignores block; only the response is stalled.
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = RESP;
                    rd_en      = 1'b1;
                end
            end
            RESP: begin
                if (!block) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Protocol state and registered response strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx_q <= '0;
            err_q <= 1'b0;
            valid <= 1'b0;
            error <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx_q <= idx_next;
            err_q <= err_next;
            valid <= (state_next == RESP);
            error <= (state_next == RESP) && err_next;
            busy  <= (state_next != IDLE);
        end
    end

    ysyx_220066_dmem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (cur_idx),
        .wr_mask (wr_mask),
        .wr_data (data_Wr),
        .rd_en   (rd_en),
        .rd_zero (err_next),
        .rd_idx  (rd_idx),
        .rd_data (data_Rd)
    );

endmodule
